// File: rtl/seg7_pkg.sv
// Shared types and BCD-to-segment decode for the 3-digit multiplexed display driver.
package seg7_pkg;

    typedef enum logic [1:0] {S_U, S_T, S_H} scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Patterns are {g,f,e,d,c,b,a}, active-low; non-BCD nibbles show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot timer: counts 0..CLK_DIV-1 per digit slot and flags the dead-time gap and slot end.
module seg7_prescaler #(
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic in_gap
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign slot_end = (cnt_q == CW'(CLK_DIV - 1));
    assign in_gap   = (cnt_q < CW'(GAP_CYC));
    assign cnt_d    = slot_end ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 3-digit multiplexed 7-segment driver with frame-synchronous digit updates.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros in the hundreds/tens slots.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dig_valid,
    output logic       dig_ready,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic        slot_end, in_gap, boundary, xfer;
    scan_state_t state_q, state_d;
    logic [11:0] pend_q, pend_d, disp_q, disp_d;   // {hund,tens,units}
    logic        pend_full_q, pend_full_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q, an_d, an_sel;
    logic [3:0]  slot_dig;
    logic        blank;

    seg7_prescaler #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .in_gap   (in_gap)
    );

    assign boundary   = slot_end && (state_q == S_H);
    assign frame_done = boundary;
    assign dig_ready  = !pend_full_q;
    assign xfer       = dig_valid && dig_ready;
    assign seg        = seg_q;
    assign an         = an_q;

    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            case (state_q)
                S_U:     state_d = S_T;
                S_T:     state_d = S_H;
                default: state_d = S_U;
            endcase
        end
    end

    // Promotion and load never collide: ready is low whenever pending is full.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = {dig3, dig2, dig1};
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        an_sel   = 3'b110;
        slot_dig = disp_q[3:0];
        blank    = 1'b0;
        case (state_q)
            S_T: begin
                an_sel   = 3'b101;
                slot_dig = disp_q[7:4];
                blank    = LZB && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
            end
            S_H: begin
                an_sel   = 3'b011;
                slot_dig = disp_q[11:8];
                blank    = LZB && (disp_q[11:8] == 4'd0);
            end
            default: ;
        endcase
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
        if (!in_gap) begin
            an_d  = an_sel;
            seg_d = blank ? SEG_BLANK : bcd_to_seg(slot_dig);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_U;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 3'b111;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CLK_DIV=8, GAP_CYC=2 and a 10 ns clock.
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 8;
    localparam int GAP_CYC = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z_LEAD = 7'h7F;
`else
    localparam logic [6:0] Z_LEAD = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dig_valid = 1'b0;
    logic [3:0] dig1 = '0, dig2 = '0, dig3 = '0;
    logic       dig_ready, frame_done;
    logic [6:0] seg;
    logic [2:0] an;

    int n_pass = 0;
    int n_total = 0;
    int cyc;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            n_total++;
            $display("FAIL wait: cyc=%0d required %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        dig_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        dig3 = h; dig2 = t; dig1 = u;
        dig_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (seg !== 7'h7F) $display("FAIL rst_seg: got %h exp 7f", seg); else n_pass++;
        n_total++; if (an !== 3'b111) $display("FAIL rst_an: got %b exp 111", an); else n_pass++;
        n_total++; if (dig_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", dig_ready); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b exp 0", frame_done); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_scan();
        logic [2:0] ea;
        logic [6:0] es;
        logic       ef;
        int p, slot;
        do_reset();
        for (int c = 1; c <= 48; c++) begin
            wait_cyc(c);
            p    = c - 1;
            slot = (p / 8) % 3;
            ef   = (c % 24) == 23;
            if ((p % 8) < 2) begin
                ea = 3'b111; es = 7'h7F;
            end else begin
                ea = (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
                es = (slot == 0) ? 7'h40 : Z_LEAD;
            end
            n_total++;
            if ({seg, an, frame_done, dig_ready} !== {es, ea, ef, 1'b1})
                $display("FAIL scan c=%0d: got seg=%h an=%b fd=%b rdy=%b exp seg=%h an=%b fd=%b rdy=1",
                         c, seg, an, frame_done, dig_ready, es, ea, ef);
            else n_pass++;
        end
    endtask

    task automatic test_frame_latch();
        do_reset();
        wait_cyc(2);
        send(4'd4, 4'd0, 4'd0);
        wait_cyc(3);
        dig_valid = 1'b0;
        n_total++; if (dig_ready !== 1'b0) $display("FAIL t2_rdy_drop: got %b exp 0", dig_ready); else n_pass++;
        wait_cyc(20);
        n_total++; if ({seg, an} !== {Z_LEAD, 3'b011}) $display("FAIL t2_old_hund: got %h/%b exp %h/011", seg, an, Z_LEAD); else n_pass++;
        wait_cyc(23);
        n_total++; if ({frame_done, dig_ready} !== 2'b10) $display("FAIL t2_boundary: got fd=%b rdy=%b exp fd=1 rdy=0", frame_done, dig_ready); else n_pass++;
        wait_cyc(24);
        n_total++; if ({frame_done, dig_ready} !== 2'b01) $display("FAIL t2_rdy_rise: got fd=%b rdy=%b exp fd=0 rdy=1", frame_done, dig_ready); else n_pass++;
        wait_cyc(28);
        n_total++; if ({seg, an} !== {7'h40, 3'b110}) $display("FAIL t2_units: got %h/%b exp 40/110", seg, an); else n_pass++;
        wait_cyc(36);
        n_total++; if ({seg, an} !== {7'h40, 3'b101}) $display("FAIL t2_tens: got %h/%b exp 40/101", seg, an); else n_pass++;
        wait_cyc(44);
        n_total++; if ({seg, an} !== {7'h19, 3'b011}) $display("FAIL t2_hund: got %h/%b exp 19/011", seg, an); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        wait_cyc(2);
        send(4'd4, 4'd0, 4'd0);
        wait_cyc(3);
        send(4'd1, 4'd2, 4'd3);
        wait_cyc(23);
        n_total++; if (dig_ready !== 1'b0) $display("FAIL t3_held: got rdy=%b exp 0", dig_ready); else n_pass++;
        wait_cyc(24);
        n_total++; if (dig_ready !== 1'b1) $display("FAIL t3_rdy_rise: got rdy=%b exp 1", dig_ready); else n_pass++;
        wait_cyc(25);
        dig_valid = 1'b0;
        n_total++; if (dig_ready !== 1'b0) $display("FAIL t3_accept: got rdy=%b exp 0", dig_ready); else n_pass++;
        wait_cyc(28);
        n_total++; if ({seg, an} !== {7'h40, 3'b110}) $display("FAIL t3_f2_units: got %h/%b exp 40/110", seg, an); else n_pass++;
        wait_cyc(44);
        n_total++; if ({seg, an} !== {7'h19, 3'b011}) $display("FAIL t3_f2_hund: got %h/%b exp 19/011", seg, an); else n_pass++;
        wait_cyc(52);
        n_total++; if ({seg, an} !== {7'h30, 3'b110}) $display("FAIL t3_f3_units: got %h/%b exp 30/110", seg, an); else n_pass++;
        wait_cyc(60);
        n_total++; if ({seg, an} !== {7'h24, 3'b101}) $display("FAIL t3_f3_tens: got %h/%b exp 24/101", seg, an); else n_pass++;
        wait_cyc(68);
        n_total++; if ({seg, an} !== {7'h79, 3'b011}) $display("FAIL t3_f3_hund: got %h/%b exp 79/011", seg, an); else n_pass++;
    endtask

    task automatic test_dash();
        do_reset();
        wait_cyc(2);
        send(4'd9, 4'hA, 4'hC);
        wait_cyc(3);
        dig_valid = 1'b0;
        wait_cyc(28);
        n_total++; if ({seg, an} !== {7'h3F, 3'b110}) $display("FAIL t4_units_dash: got %h/%b exp 3f/110", seg, an); else n_pass++;
        wait_cyc(36);
        n_total++; if ({seg, an} !== {7'h3F, 3'b101}) $display("FAIL t4_tens_dash: got %h/%b exp 3f/101", seg, an); else n_pass++;
        wait_cyc(44);
        n_total++; if ({seg, an} !== {7'h10, 3'b011}) $display("FAIL t4_hund_9: got %h/%b exp 10/011", seg, an); else n_pass++;
    endtask

    task automatic test_blank();
        do_reset();
        wait_cyc(2);
        send(4'd0, 4'd0, 4'd7);
        wait_cyc(3);
        dig_valid = 1'b0;
        wait_cyc(26);
        send(4'd0, 4'd5, 4'd0);
        wait_cyc(27);
        dig_valid = 1'b0;
        wait_cyc(28);
        n_total++; if ({seg, an} !== {7'h78, 3'b110}) $display("FAIL t5_007_units: got %h/%b exp 78/110", seg, an); else n_pass++;
        wait_cyc(36);
        n_total++; if ({seg, an} !== {Z_LEAD, 3'b101}) $display("FAIL t5_007_tens: got %h/%b exp %h/101", seg, an, Z_LEAD); else n_pass++;
        wait_cyc(44);
        n_total++; if ({seg, an} !== {Z_LEAD, 3'b011}) $display("FAIL t5_007_hund: got %h/%b exp %h/011", seg, an, Z_LEAD); else n_pass++;
        wait_cyc(52);
        n_total++; if ({seg, an} !== {7'h40, 3'b110}) $display("FAIL t5_050_units: got %h/%b exp 40/110", seg, an); else n_pass++;
        wait_cyc(60);
        n_total++; if ({seg, an} !== {7'h12, 3'b101}) $display("FAIL t5_050_tens: got %h/%b exp 12/101", seg, an); else n_pass++;
        wait_cyc(68);
        n_total++; if ({seg, an} !== {Z_LEAD, 3'b011}) $display("FAIL t5_050_hund: got %h/%b exp %h/011", seg, an, Z_LEAD); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_cyc(10);
        send(4'd1, 4'd2, 4'd3);
        wait_cyc(11);
        dig_valid = 1'b0;
        wait_cyc(13);
        n_total++; if ({seg, an, dig_ready} !== {Z_LEAD, 3'b101, 1'b0}) $display("FAIL t6_pre: got %h/%b rdy=%b exp %h/101 rdy=0", seg, an, dig_ready, Z_LEAD); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_total++; if ({seg, an, dig_ready, frame_done} !== {7'h7F, 3'b111, 1'b1, 1'b0})
            $display("FAIL t6_async: got %h/%b rdy=%b fd=%b exp 7f/111 rdy=1 fd=0", seg, an, dig_ready, frame_done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(1);
        n_total++; if (an !== 3'b111) $display("FAIL t6_restart_gap: got an=%b exp 111", an); else n_pass++;
        wait_cyc(4);
        n_total++; if ({seg, an} !== {7'h40, 3'b110}) $display("FAIL t6_restart_su: got %h/%b exp 40/110", seg, an); else n_pass++;
        wait_cyc(28);
        n_total++; if ({seg, an} !== {7'h40, 3'b110}) $display("FAIL t6_units_000: got %h/%b exp 40/110", seg, an); else n_pass++;
        wait_cyc(44);
        n_total++; if ({seg, an} !== {Z_LEAD, 3'b011}) $display("FAIL t6_hund_000: got %h/%b exp %h/011", seg, an, Z_LEAD); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_latch();
        test_back_to_back();
        test_dash();
        test_blank();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
